// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern streamer and the sequence detector benches:
// state encoding, length-width helper and the reference test pattern.
package pattern_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bits needed to hold a length in the range 0..width.
    function automatic int len_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam logic [4:0] PAT_10110     = 5'b10110;
    localparam int         PAT_LEN_10110 = 5;

endpackage

// File: rtl/serial_pattern_streamer.sv
// Parallel-to-serial stage: accepts variable-length words over valid/ready and streams
// them MSB-first, one bit per clock, with no gap between consecutive words.
module serial_pattern_streamer
    import pattern_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [len_w(WIDTH)-1:0]    load_len,
    input  logic                       abort,
    output logic                       load_ready,
    output logic                       dout,
    output logic                       dout_valid,
    output logic                       last
);

    localparam int LEN_W = len_w(WIDTH);

    logic [WIDTH-1:0] shreg, shreg_nxt, aligned;
    logic [LEN_W-1:0] cnt, cnt_nxt, len_c;
    logic             dout_nxt, accept;
    state_t           state;

    // The FSM state is fully determined by the bit counter.
    assign state      = (cnt == '0) ? ST_IDLE : ST_SHIFT;
    assign load_ready = (cnt <= LEN_W'(1));
    assign dout_valid = (state == ST_SHIFT);
    assign last       = (cnt == LEN_W'(1));

    assign len_c  = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
    assign accept = load_valid && load_ready && (load_len != '0) && !abort;

    always_comb begin
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        dout_nxt  = dout;
        // Left-align the valid bits so the first one sits in the MSB.
        aligned   = load_data << (LEN_W'(WIDTH) - len_c);
        if (abort) begin
            cnt_nxt   = '0;
            shreg_nxt = '0;
            dout_nxt  = IDLE_BIT;
        end else if (accept) begin
            cnt_nxt   = len_c;
            dout_nxt  = aligned[WIDTH-1];
            shreg_nxt = aligned << 1;
        end else begin
            case (state)
                ST_SHIFT: begin
                    cnt_nxt   = cnt - LEN_W'(1);
                    shreg_nxt = shreg << 1;
                    dout_nxt  = (cnt == LEN_W'(1)) ? IDLE_BIT : shreg[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            shreg <= '0;
            dout  <= IDLE_BIT;
        end else begin
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            dout  <= dout_nxt;
        end
    end

endmodule

// File: doc/serial_pattern_streamer.md
# serial_pattern_streamer

Parallel-to-serial stimulus stage that sits directly upstream of the serial sequence detectors (Moore/Mealy pattern detectors). It accepts variable-length bit words through a valid/ready handshake and drives them MSB-first, one bit per clock, onto the detector's `din` input. Consecutive words are streamed with no gap cycles, so overlapping patterns that span word boundaries reach the detector intact.

## Interface
- `WIDTH`, default 8: maximum word length in bits, must be ≥ 2.
- `IDLE_BIT`, default 1'b0: value driven on `dout` while no bit is valid.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-low.
- `load_valid`  in  1  word offered on `load_data` / `load_len`.
- `load_data`  in  WIDTH  word; the valid bits are `load_data[load_len-1:0]`.
- `load_len`  in  $clog2(WIDTH+1)  number of bits to send.
- `abort`  in  1  synchronous flush of the current word.
- `load_ready`  out  1  stage can accept a word this cycle.
- `dout`  out  1  serial bit, connects to the detector `din`.
- `dout_valid`  out  1  `dout` carries a payload bit.
- `last`  out  1  the current `dout` is the final bit of its word.

## Operation
- Internal state:
  - `shreg[WIDTH-1:0]`, left-aligned with the next bit in the MSB.
  - `cnt`, the bits remaining including the bit currently on `dout`.
  - FSM states `ST_IDLE` (`cnt==0`) and `ST_SHIFT` (`cnt≥1`).
- Combinational outputs:
  - `load_ready = (cnt <= 1)`.
  - `dout_valid = (cnt != 0)`.
  - `last = (cnt == 1)`.
- Accept: occurs when `load_valid && load_ready && load_len != 0 && !abort`.
  - `dout <= load_data[L-1]`.
  - `shreg <= load_data << (WIDTH-L+1)`.
  - `cnt <= L`, where `L = min(load_len, WIDTH)`.
- Lengths above `WIDTH` are clamped to `WIDTH`.
- `load_len==0` with `load_valid`: the word is consumed (handshake completes), nothing is emitted, and the state is unchanged.
- Shift: when `cnt ≥ 1` and there is no accept:
  - `dout <= shreg[WIDTH-1]`, `shreg <= shreg << 1`, `cnt <= cnt-1`.
  - When `cnt` goes to 0, `dout <= IDLE_BIT`.
- Back-to-back: while `last` is high, `load_ready` is high. A word accepted in that cycle puts its first bit on `dout` in the very next cycle, so there are zero bubble cycles.
- Abort:
  - Takes priority over both accept and shift.
  - Next edge: `cnt <= 0`, `dout <= IDLE_BIT`, `shreg <= 0`.
  - A `load_valid` in the same cycle is not accepted; the source must hold it.
- The upstream source must hold `load_data`/`load_len` stable while `load_valid && !load_ready`.

## Timing
- Reset (async assert, sync-safe deassert by the system) sets:
  - `cnt=0`, `shreg=0`, `dout=IDLE_BIT`.
  - Therefore `dout_valid=0`, `last=0`, `load_ready=1`.
- Latency: a word accepted at edge N presents its bit `L-1` in cycle N+1 and its bit 0 in cycle N+L.
- Throughput: 1 bit/clock sustained, with no idle cycles between words.
- `dout` is a flop output and therefore glitch-free toward the detector.
- `dout_valid`, `last` and `load_ready` are decoded from `cnt` (a flop), so they have no combinational path from inputs.
- Reset asserted mid-word: all state clears immediately and the partial word is lost. A downstream detector reset separately must not rely on a partial word completing.
- `L==1` word: `last` is high in the first output cycle, and the next word can be accepted in that same cycle.

## Structure
- Shared package `pattern_pkg` holds:
  - the state encoding `ST_IDLE`/`ST_SHIFT`;
  - the `LEN_W = $clog2(WIDTH+1)` helper;
  - the test-pattern constants `PAT_10110 = 5'b10110` and `PAT_LEN_10110 = 5`, which are also used by the detector benches.
- Single module, no sub-modules. The shift register and counter are small enough to remain inline.

## Test plan
- Reset check: `rst=0` with `load_valid=1` → `dout=IDLE_BIT`, `dout_valid=0`, `load_ready=1`, and nothing is accepted.
- Single word: `load_data=8'h16`, `load_len=5` → `dout`=1,0,1,1,0 over 5 consecutive cycles; `last` is high on the 5th bit only; `dout_valid` then drops and `dout=IDLE_BIT`.
- Back-to-back: `5'b10110` then `load_data=8'h06`, `load_len=3` held valid → 8 contiguous bits 1,0,1,1,0,1,1,0 with no gap. A chained Moore 10110 detector must assert twice (the overlap case).
- Clamp and zero length:
  - `load_len=WIDTH+1` → exactly `WIDTH` bits.
  - `load_len=0` → handshake completes, with zero `dout_valid` cycles.
- Abort mid-word: abort on the 3rd bit of `10110` → the next cycle shows `dout_valid=0`, `dout=IDLE_BIT`; a concurrent `load_valid` is stalled, then accepted the cycle after.
- Async reset mid-word: drop `rst` between clock edges during bit 2 → outputs return to reset values before the next edge.
